router_ctrl_fsm: RTL

- Control FSM for the 1x3 router datapath.
- Decodes the header address and sequences the register block through header load, payload load, FIFO-full stall, parity load and parity check.
- Gates FIFO writes and raises busy toward the source.
- Maintains packet and drop counters for status.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_ctrl_fsm.sv | 122 ++++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// The output-decode helpers keep the state-to-flag mapping in one place.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int         NUM_PORTS    = 3;

  function automatic logic is_write_state(input state_t s);
    return (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
  endfunction

  // The source may only present new bytes while decoding a header or streaming payload.
  function automatic logic is_busy_state(input state_t s);
    return !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
  endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Control FSM for the 1x3 router: header decode, load sequencing, FIFO write gating,
// busy toward the source, and accepted/dropped packet counters.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [1:0]       data_in,
  input  logic             fifo_full,
  input  logic             fifo_empty_0,
  input  logic             fifo_empty_1,
  input  logic             fifo_empty_2,
  input  logic             soft_reset_0,
  input  logic             soft_reset_1,
  input  logic             soft_reset_2,
  input  logic             parity_done,
  input  logic             low_pkt_valid,
  output logic             detect_add,
  output logic             lfd_state,
  output logic             ld_state,
  output logic             laf_state,
  output logic             full_state,
  output logic             rst_int_reg,
  output logic             write_enb_reg,
  output logic             busy,
  output logic [1:0]       dest_addr,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count
);

  state_t             r_state;
  logic [1:0]         r_dest_addr;
  logic [CNT_W-1:0]   r_pkt_count;
  logic [CNT_W-1:0]   r_drop_count;
  logic               r_detect_add, r_lfd, r_ld, r_laf, r_full, r_rst_int;
  logic               r_write_enb, r_busy;

  state_t             w_next;
  logic [1:0]         w_addr;
  logic [3:0]         w_empty_vec;
  logic [3:0]         w_srst_vec;
  logic               w_tgt_empty;
  logic               w_srst;
  logic               w_hdr_valid;
  logic               w_hdr_drop;

  // Slot 3 is padding so the invalid address indexes a constant 0.
  assign w_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

  always_comb begin
    w_addr      = (r_state == DECODE_ADDRESS) ? data_in : r_dest_addr;
    w_tgt_empty = w_empty_vec[w_addr];
    w_srst      = (r_state != DECODE_ADDRESS) && w_srst_vec[r_dest_addr];
    w_hdr_valid = (r_state == DECODE_ADDRESS) && pkt_valid && (data_in != ADDR_INVALID);
    w_hdr_drop  = (r_state == DECODE_ADDRESS) && pkt_valid && (data_in == ADDR_INVALID);
    w_next      = r_state;
    case (r_state)
      DECODE_ADDRESS:     if (w_hdr_valid) w_next = w_tgt_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:    if (w_tgt_empty) w_next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    w_next = LOAD_DATA;
      LOAD_DATA:          if (fifo_full)       w_next = FIFO_FULL_STATE;
                          else if (!pkt_valid) w_next = LOAD_PARITY;
      FIFO_FULL_STATE:    if (!fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    if (parity_done)        w_next = DECODE_ADDRESS;
                          else if (low_pkt_valid) w_next = LOAD_PARITY;
                          else                    w_next = LOAD_DATA;
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
    // Port timeout abandons the packet regardless of where the sequence is.
    if (w_srst) w_next = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= DECODE_ADDRESS;
      r_dest_addr  <= 2'd0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_detect_add <= 1'b1;
      r_lfd        <= 1'b0;
      r_ld         <= 1'b0;
      r_laf        <= 1'b0;
      r_full       <= 1'b0;
      r_rst_int    <= 1'b0;
      r_write_enb  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hdr_valid) r_dest_addr <= data_in;
      if (w_hdr_drop)  r_drop_count <= r_drop_count + 1'b1;
      if ((r_state == LOAD_FIRST_DATA) && !w_srst) r_pkt_count <= r_pkt_count + 1'b1;
      // Flags are registered from the next state so they always match r_state.
      r_detect_add <= (w_next == DECODE_ADDRESS);
      r_lfd        <= (w_next == LOAD_FIRST_DATA);
      r_ld         <= (w_next == LOAD_DATA);
      r_laf        <= (w_next == LOAD_AFTER_FULL);
      r_full       <= (w_next == FIFO_FULL_STATE);
      r_rst_int    <= (w_next == CHECK_PARITY_ERROR);
      r_write_enb  <= is_write_state(w_next);
      r_busy       <= is_busy_state(w_next);
    end
  end

  assign detect_add    = r_detect_add;
  assign lfd_state     = r_lfd;
  assign ld_state      = r_ld;
  assign laf_state     = r_laf;
  assign full_state    = r_full;
  assign rst_int_reg   = r_rst_int;
  assign write_enb_reg = r_write_enb;
  assign busy          = r_busy;
  assign dest_addr     = r_dest_addr;
  assign pkt_count     = r_pkt_count;
  assign drop_count    = r_drop_count;

endmodule
